// File: rtl/instruction_set.sv
// Shared ISA-level definitions for the z8ProcessorCore fetch path.
package instruction_set;

  // Instruction width is fixed by the ISA: 16 + 16 + 8 bits over three memory beats.
  localparam int INSTR_W         = 40;
  localparam int WORDS_PER_INSTR = 3;

  // Beat of the instruction currently being requested from program memory.
  typedef enum logic [1:0] {
    BEAT0 = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } FETCH_STATE_T;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: assembles 40-bit instructions from three 16-bit
// program-memory beats and hands them to the control unit over valid/ready.
// Instruction n lives at words 3n, 3n+1 and 3n+2 (low byte only).
module instruction_fetch_unit
  import instruction_set::*;
#(
  parameter int ADDR_W  = 16,
  parameter int WORD_W  = 16,
  parameter int INSTR_W = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic [WORD_W-1:0]  imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  FETCH_STATE_T       state_r;
  FETCH_STATE_T       state_next_s;
  logic [ADDR_W-1:0]  fetch_pc_r;
  logic [ADDR_W-1:0]  addr_pc_s;
  logic [ADDR_W-1:0]  base_s;
  logic [ADDR_W-1:0]  beat_off_s;
  logic               req_s;
  logic               grant_s;

  logic               rsp_pending_r;
  FETCH_STATE_T       rsp_beat_r;
  logic               drop_r;
  logic               rsp_live_s;
  logic               rsp_last_s;

  logic [WORD_W-1:0]  slot0_r;
  logic [WORD_W-1:0]  slot1_r;

  logic               instr_valid_r;
  logic [INSTR_W-1:0] instr_out_r;
  logic [ADDR_W-1:0]  instr_pc_r;

  // A response is usable unless it belongs to a grant made in a redirect cycle.
  // When the final beat lands, the next instruction's first beat (possibly
  // granted in that same cycle) must already address PC+1.
  always_comb begin
    rsp_live_s = rsp_pending_r && !drop_r;
    rsp_last_s = rsp_live_s && (rsp_beat_r == BEAT2);
    if (rsp_last_s) begin
      addr_pc_s = fetch_pc_r + PC_ONE;
    end else begin
      addr_pc_s = fetch_pc_r;
    end
    base_s = addr_pc_s * ADDR_W'(WORDS_PER_INSTR);
  end

  // FSM next-state and memory request decode; the last beat waits until the
  // output register is known to be free when its data returns.
  always_comb begin
    state_next_s = state_r;
    req_s        = 1'b0;
    beat_off_s   = '0;
    case (state_r)
      BEAT0: begin
        req_s        = 1'b1;
        beat_off_s   = {ADDR_W{1'b0}};
        state_next_s = BEAT1;
      end
      BEAT1: begin
        req_s        = 1'b1;
        beat_off_s   = {{(ADDR_W-2){1'b0}}, 2'd1};
        state_next_s = BEAT2;
      end
      BEAT2: begin
        req_s        = !instr_valid_r || instr_ready;
        beat_off_s   = {{(ADDR_W-2){1'b0}}, 2'd2};
        state_next_s = BEAT0;
      end
      default: begin
        req_s        = 1'b0;
        beat_off_s   = {ADDR_W{1'b0}};
        state_next_s = BEAT0;
      end
    endcase

    grant_s = req_s && imem_gnt && !reset;

    if (redirect) begin
      state_next_s = BEAT0;
    end else if (!grant_s) begin
      state_next_s = state_r;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // Memory interface outputs are forced quiet while reset is held.
  always_comb begin
    if (reset) begin
      imem_req  = 1'b0;
      imem_addr = {ADDR_W{1'b0}};
    end else begin
      imem_req  = req_s;
      imem_addr = base_s + beat_off_s;
    end
  end

  // Beat state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= BEAT0;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Response tracker: which beat returns next cycle and whether it is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_pending_r <= 1'b0;
      rsp_beat_r    <= BEAT0;
      drop_r        <= 1'b0;
    end else begin
      rsp_pending_r <= grant_s;
      rsp_beat_r    <= state_r;
      drop_r        <= redirect && grant_s;
    end
  end

  // Capture the first two beats of the instruction being assembled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0_r <= {WORD_W{1'b0}};
      slot1_r <= {WORD_W{1'b0}};
    end else if (!redirect && rsp_live_s) begin
      case (rsp_beat_r)
        BEAT0:   slot0_r <= imem_rdata;
        BEAT1:   slot1_r <= imem_rdata;
        default: slot0_r <= slot0_r;
      endcase
    end else begin
      slot0_r <= slot0_r;
    end
  end

  // Fetch PC: redirect target, or step (with wrap) once an instruction completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r <= {ADDR_W{1'b0}};
    end else if (redirect) begin
      fetch_pc_r <= redirect_pc;
    end else if (rsp_last_s) begin
      fetch_pc_r <= fetch_pc_r + PC_ONE;
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  // Output register: load on final beat, hold while stalled, clear after transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid_r <= 1'b0;
      instr_out_r   <= {INSTR_W{1'b0}};
      instr_pc_r    <= {ADDR_W{1'b0}};
    end else if (redirect) begin
      instr_valid_r <= 1'b0;
    end else if (rsp_last_s) begin
      instr_valid_r <= 1'b1;
      instr_out_r   <= {slot0_r, slot1_r, imem_rdata[7:0]};
      instr_pc_r    <= fetch_pc_r;
    end else if (instr_valid_r && instr_ready) begin
      instr_valid_r <= 1'b0;
    end else begin
      instr_valid_r <= instr_valid_r;
    end
  end

  assign instr_valid = instr_valid_r;
  assign instr_out   = instr_out_r;
  assign instr_pc    = instr_pc_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed latency/stall/redirect/
// reset scenarios followed by randomized grant/ready/redirect traffic, all checked
// by a scoreboard fed from an instruction-level reference model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [39:0] instr_out;
  logic [15:0] instr_pc;

  instruction_fetch_unit dut (
    .clk         (clk),
    .reset       (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] pc;
    logic [39:0] ins;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model state: instruction being fetched and how many beats granted.
  logic [15:0] m_pc;
  int          m_beat;
  logic        prev_grant;
  logic [15:0] prev_addr;
  logic        prev_hold;
  logic [39:0] prev_out;
  logic [15:0] prev_pc;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  function automatic logic [39:0] exp_instr(input logic [15:0] pc);
    logic [15:0] b;
    logic [15:0] w2;
    b  = pc * 16'd3;
    w2 = mem_word(b + 16'd2);
    return {mem_word(b), mem_word(b + 16'd1), w2[7:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge and present memory read data.
  task automatic tick();
    @(posedge clk);
    #1;
    if (prev_grant) imem_rdata = mem_word(prev_addr);
    else            imem_rdata = 16'($urandom);
  endtask

  // Reset, check reset values, release; returns inside cycle 0.
  task automatic do_reset(input logic g, input logic r);
    tick();
    rst = 1'b1;
    redirect = 1'b0;
    repeat (3) tick();
    chk("rst_req",   {63'd0, imem_req},    64'd0);
    chk("rst_addr",  {48'd0, imem_addr},   64'd0);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_out",   {24'd0, instr_out},   64'd0);
    chk("rst_pc",    {48'd0, instr_pc},    64'd0);
    tick();
    rst = 1'b0;
    imem_gnt = g;
    instr_ready = r;
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  initial begin
    exp_t        e;
    logic        exp_req;
    logic        grant;
    logic [15:0] ea;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        m_pc = 16'd0;
        m_beat = 0;
        prev_grant = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", {63'd0, instr_valid}, 64'd1);
          chk("hold_out",   {24'd0, instr_out},   {24'd0, prev_out});
          chk("hold_pc",    {48'd0, instr_pc},    {48'd0, prev_pc});
        end
        if (instr_valid && instr_ready) begin
          if (sb_q.size() == 0) begin
            chk("spurious_valid", {63'd0, instr_valid}, 64'd0);
          end else begin
            e = sb_q.pop_front();
            chk("deliver_pc",    {48'd0, instr_pc},  {48'd0, e.pc});
            chk("deliver_instr", {24'd0, instr_out}, {24'd0, e.ins});
          end
        end
        exp_req = (m_beat != 2) || !instr_valid || instr_ready;
        chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
        grant = imem_req && imem_gnt;
        if (grant) begin
          ea = m_pc * 16'd3 + 16'(m_beat);
          chk("imem_addr", {48'd0, imem_addr}, {48'd0, ea});
        end
        if (redirect) begin
          sb_q.delete();
          m_pc = redirect_pc;
          m_beat = 0;
        end else if (grant) begin
          if (m_beat == 2) begin
            e.pc = m_pc;
            e.ins = exp_instr(m_pc);
            sb_q.push_back(e);
            m_pc = m_pc + 16'd1;
            m_beat = 0;
          end else begin
            m_beat = m_beat + 1;
          end
        end
        prev_grant = grant;
        prev_addr  = imem_addr;
        prev_hold  = instr_valid && !instr_ready && !redirect;
        prev_out   = instr_out;
        prev_pc    = instr_pc;
      end
    end
  end

  // Stimulus.
  initial begin
    int   first;
    logic found;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 16'd0;
    imem_gnt = 1'b0;
    imem_rdata = 16'd0;
    instr_ready = 1'b0;
    prev_grant = 1'b0;
    prev_addr = 16'd0;
    m_pc = 16'd0;
    m_beat = 0;
    prev_hold = 1'b0;

    // Latency and throughput with grant and ready always high.
    do_reset(1'b1, 1'b1);
    first = -1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      if (instr_valid && first < 0) first = c;
      if (c == 4) begin
        chk("t1_out0", {24'd0, instr_out}, {24'd0, 40'hA000_A001_02});
        chk("t1_pc0",  {48'd0, instr_pc},  64'd0);
      end
      if (c == 7) begin
        chk("t1_out1", {24'd0, instr_out}, {24'd0, 40'hA003_A004_05});
        chk("t1_pc1",  {48'd0, instr_pc},  64'd1);
      end
    end
    chk("t1_first_valid_cycle", 64'(first), 64'd4);

    // Consumer stalls after the first instruction, then releases.
    do_reset(1'b1, 1'b0);
    for (int c = 1; c <= 12; c++) tick();
    chk("t2_out_held", {24'd0, instr_out}, {24'd0, 40'hA000_A001_02});
    instr_ready = 1'b1;
    tick();
    chk("t2_gap_valid", {63'd0, instr_valid}, 64'd0);
    tick();
    chk("t2_valid", {63'd0, instr_valid}, 64'd1);
    chk("t2_pc",    {48'd0, instr_pc},    64'd1);

    // Redirect in the cycle that beat 1 of PC 2 is granted.
    do_reset(1'b1, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (m_pc == 16'd2 && m_beat == 1) found = 1'b1;
    end
    chk("t4_reach_pc2_beat1", {63'd0, found}, 64'd1);
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    redirect = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      tick();
      if (instr_valid) found = 1'b1;
    end
    chk("t4_valid",  {63'd0, found},     64'd1);
    chk("t4_pc",     {48'd0, instr_pc},  64'h0010);
    chk("t4_instr",  {24'd0, instr_out}, {24'd0, exp_instr(16'h0010)});

    // Redirect to the top of the address space and wrap.
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      tick();
      if (instr_valid) found = 1'b1;
    end
    chk("t5_valid_ffff", {63'd0, found},     64'd1);
    chk("t5_pc_ffff",    {48'd0, instr_pc},  64'hFFFF);
    chk("t5_instr_ffff", {24'd0, instr_out}, {24'd0, exp_instr(16'hFFFF)});
    tick();
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      tick();
      if (instr_valid) found = 1'b1;
    end
    chk("t5_valid_wrap", {63'd0, found},     64'd1);
    chk("t5_pc_wrap",    {48'd0, instr_pc},  64'h0000);
    chk("t5_instr_wrap", {24'd0, instr_out}, {24'd0, 40'hA000_A001_02});

    // Grant toggling 1,0,1,0 ...
    for (int c = 0; c < 40; c++) begin
      tick();
      imem_gnt = c[0];
    end

    // Asynchronous reset in the middle of BEAT1.
    imem_gnt = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (m_beat == 1 && instr_valid) found = 1'b1;
    end
    chk("t6_reach_beat1", {63'd0, found}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_req_drop",   {63'd0, imem_req},    64'd0);
    chk("t6_valid_drop", {63'd0, instr_valid}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      tick();
      if (instr_valid) found = 1'b1;
    end
    chk("t6_restart_valid", {63'd0, found},    64'd1);
    chk("t6_restart_pc",    {48'd0, instr_pc}, 64'd0);

    // Randomized grant / ready / redirect traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      imem_gnt    = ($urandom_range(0, 99) < 70);
      instr_ready = ($urandom_range(0, 99) < 65);
      redirect    = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 16'h0010;
        1:       redirect_pc = 16'hFFFF;
        2:       redirect_pc = 16'hFFFE;
        default: redirect_pc = 16'($urandom);
      endcase
    end

    // Drain with everything enabled.
    redirect = 1'b0;
    imem_gnt = 1'b1;
    instr_ready = 1'b1;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
